// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the register file's single write port between the pipeline write-back
// stage and a multi-cycle execution unit. The pipeline always wins; multi-cycle
// results that lose the port are parked in a 2-entry FIFO and drained in cycles
// without a pipeline write. Pipeline writes are younger than anything buffered,
// so a pipeline write to address A squashes buffered entries (and a same-cycle
// mc result) targeting A. Address 31 (XZR) is consumed but never written.
//
// Optional feature (macro WB_ARB_STARVE_EN): a starvation guard that stalls the
// pipeline for one cycle after STARVE_MAX consecutive pipe grants with a
// non-empty FIFO, forcing a drain. Without the macro pipe_stall is tied low.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   pipe_wen/addr/data     write-back stage write request
//   mc_valid/addr/data     multi-cycle unit result; mc_ready accepts it
//   rf_wen/addr/data       register file write port (combinational)
//   pipe_stall             pipeline must hold its write-back stage
//   buf_count              FIFO occupancy, 0..2
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_wen,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              pipe_stall,
    output logic [1:0]        buf_count
);

    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(31);

    // FIFO storage and pointers
    logic [ADDR_W-1:0] mem_addr_q [2];
    logic [DATA_W-1:0] mem_data_q [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    logic              pipe_eff;
    logic              mc_acc;
    logic              has_head;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              kill_first;
    logic              kill_second;
    logic              tail_mid;

    // Grant and squash decode
    always_comb begin
        pipe_eff    = pipe_wen && !pipe_stall;
        mc_ready    = (count_q != 2'd2);
        mc_acc      = mc_valid && mc_ready;
        has_head    = (count_q != 2'd0);
        pop         = !pipe_eff && has_head;
        bypass      = !pipe_eff && !has_head && mc_acc;
        kill_first  = pipe_eff && has_head && (mem_addr_q[head_q] == pipe_addr);
        kill_second = pipe_eff && (count_q == 2'd2) && (mem_addr_q[~head_q] == pipe_addr);
        // A same-cycle mc result to the pipe's address is older, so it is dropped.
        push        = mc_acc && !bypass && !(pipe_eff && (mc_addr == pipe_addr));
    end

    // FIFO next state. Removing the oldest entry advances head; removing the
    // younger entry of a full FIFO retreats tail. A push then lands at the
    // retreated tail so the survivors stay contiguous.
    always_comb begin
        head_d   = head_q;
        tail_mid = tail_q;
        if (pop || kill_first) begin
            head_d = ~head_q;
        end
        if (kill_second) begin
            tail_mid = ~tail_q;
        end
        tail_d  = push ? ~tail_mid : tail_mid;
        count_d = count_q - 2'(pop || kill_first) - 2'(kill_second) + 2'(push);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; count gates its validity.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            mem_addr_q[tail_mid] <= mc_addr;
            mem_data_q[tail_mid] <= mc_data;
        end
    end

    // Write port mux; defaults to the pipe inputs when nothing is granted.
    always_comb begin
        rf_addr = pipe_addr;
        rf_data = pipe_data;
        if (!pipe_eff) begin
            if (has_head) begin
                rf_addr = mem_addr_q[head_q];
                rf_data = mem_data_q[head_q];
            end else if (mc_acc) begin
                rf_addr = mc_addr;
                rf_data = mc_data;
            end
        end
        // Inputs are masked while reset is held low.
        rf_wen    = reset && (pipe_eff || has_head || mc_acc) && (rf_addr != XZR);
        buf_count = count_q;
    end

`ifdef WB_ARB_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d, starve_inc;
    logic             stall_q, stall_d;

    // Count consecutive pipe grants that leave buffered work waiting; on reaching
    // the threshold stall the pipe for one cycle so the head drains.
    always_comb begin
        starve_inc = (pipe_eff && has_head) ? starve_q + CNT_W'(1) : '0;
        stall_d    = (starve_inc == CNT_W'(STARVE_MAX));
        starve_d   = stall_d ? '0 : starve_inc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign pipe_stall = stall_q;
`else
    logic unused_starve_max;
    assign unused_starve_max = |32'(STARVE_MAX);
    assign pipe_stall        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int SM = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pipe_wen = 1'b0;
    logic [AW-1:0] pipe_addr = '0;
    logic [DW-1:0] pipe_data = '0;
    logic          mc_valid = 1'b0;
    logic [AW-1:0] mc_addr = '0;
    logic [DW-1:0] mc_data = '0;
    logic          mc_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          pipe_stall;
    logic [1:0]    buf_count;

    wb_port_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_MAX (SM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_wen   (pipe_wen),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .mc_valid   (mc_valid),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .rf_wen     (rf_wen),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .pipe_stall (pipe_stall),
        .buf_count  (buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    // Reference model: ordered list of parked mc results plus starvation state.
    ent_t m_fifo[$];
    exp_t exp_q[$];
    int   m_cnt = 0;
    bit   m_stall = 0;

    int   n_tests = 0;
    int   n_fail = 0;
    bit   stall_seen = 0;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: one expected write-port response per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rf_wen", rf_wen, e.wen);
            if (e.wen && rf_wen) begin
                chk("rf_addr", rf_addr, e.addr);
                chk("rf_data", rf_data, e.data);
            end
        end else begin
            chk("rf_wen_idle", rf_wen, 1'b0);
        end
    end

    task automatic step(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        exp_t          e;
        ent_t          n;
        bit            eff, acc, w;
        int            sz;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        @(posedge clk);
        #1;
        pipe_wen  = pw;
        pipe_addr = pa;
        pipe_data = pd;
        mc_valid  = mv;
        mc_addr   = ma;
        mc_data   = md;
        sz  = m_fifo.size();
        eff = pw && !m_stall;
        acc = mv && (sz != 2);
        w   = 0;
        wa  = pa;
        wd  = pd;
        n.addr = ma;
        n.data = md;
        if (eff) begin
            w = 1;
            for (int i = sz - 1; i >= 0; i--) begin
                if (m_fifo[i].addr == pa) m_fifo.delete(i);
            end
            if (acc && ma != pa) m_fifo.push_back(n);
        end else if (sz > 0) begin
            w  = 1;
            wa = m_fifo[0].addr;
            wd = m_fifo[0].data;
            void'(m_fifo.pop_front());
            if (acc) m_fifo.push_back(n);
        end else if (acc) begin
            w  = 1;
            wa = ma;
            wd = md;
        end
        e.wen  = w && (wa != AW'(31));
        e.addr = wa;
        e.data = wd;
        exp_q.push_back(e);
        #2;
        chk("buf_count", buf_count, sz);
        chk("mc_ready", mc_ready, (sz != 2));
        chk("pipe_stall", pipe_stall, m_stall);
        stall_seen = pipe_stall;
`ifdef WB_ARB_STARVE_EN
        if (eff && sz > 0) m_cnt++;
        else m_cnt = 0;
        m_stall = (m_cnt == SM);
        if (m_stall) m_cnt = 0;
`else
        m_stall = 0;
`endif
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset(input bit busy, input int cycles);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        pipe_wen  = busy;
        pipe_addr = AW'(2);
        pipe_data = {$urandom, $urandom};
        mc_valid  = busy;
        mc_addr   = AW'(3);
        mc_data   = {$urandom, $urandom};
        #1;
        chk("rst_buf_count", buf_count, 2'd0);
        chk("rst_mc_ready", mc_ready, 1'b1);
        chk("rst_pipe_stall", pipe_stall, 1'b0);
        chk("rst_rf_wen", rf_wen, 1'b0);
        m_fifo.delete();
        exp_q.delete();
        m_cnt   = 0;
        m_stall = 0;
        repeat (cycles) @(posedge clk);
        #1;
        pipe_wen = 1'b0;
        mc_valid = 1'b0;
        reset    = 1'b1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 9) == 0) a = AW'(31);
        else a = AW'($urandom_range(1, 4));
        return a;
    endfunction

    initial begin
        int first_stall;
        int n_stall;

        apply_reset(1'b0, 2);
        #2;
        chk("idle_rf_wen", rf_wen, 1'b0);
        chk("idle_mc_ready", mc_ready, 1'b1);
        chk("idle_buf_count", buf_count, 2'd0);
        chk("idle_pipe_stall", pipe_stall, 1'b0);

        // mc bypass with pipe idle and empty FIFO
        step(1'b0, '0, '0, 1'b1, AW'(3), 64'hAA);
        chk("byp_wen", rf_wen, 1'b1);
        chk("byp_addr", rf_addr, AW'(3));
        chk("byp_data", rf_data, 64'hAA);
        idle();
        chk("byp_count", buf_count, 2'd0);

        // pipe holds the port for 4 cycles while mc delivers 4 then 5
        step(1'b1, AW'(1), 64'h11, 1'b1, AW'(4), 64'h44);
        step(1'b1, AW'(1), 64'h12, 1'b1, AW'(5), 64'h55);
        step(1'b1, AW'(1), 64'h13, 1'b0, '0, '0);
        chk("full_mc_ready", mc_ready, 1'b0);
        step(1'b1, AW'(1), 64'h14, 1'b0, '0, '0);
        idle();
        chk("drain0_addr", rf_addr, AW'(4));
        idle();
        chk("drain1_addr", rf_addr, AW'(5));
        idle();

        // buffered entry to 7 squashed by a younger pipe write to 7
        step(1'b1, AW'(1), 64'h21, 1'b1, AW'(7), 64'h77);
        step(1'b1, AW'(7), 64'h55, 1'b0, '0, '0);
        idle();
        chk("squash_count", buf_count, 2'd0);
        chk("squash_no_write", rf_wen, 1'b0);

        // XZR from both sources in one cycle
        step(1'b1, AW'(31), 64'h1, 1'b1, AW'(31), 64'h2);
        chk("xzr_wen", rf_wen, 1'b0);
        idle();
        chk("xzr_count", buf_count, 2'd0);

        // starvation: one entry parked, then a continuous pipe stream
        step(1'b1, AW'(1), 64'h31, 1'b1, AW'(9), 64'h99);
        first_stall = 0;
        n_stall     = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, AW'(1), {$urandom, $urandom}, 1'b0, '0, '0);
            if (stall_seen) begin
                n_stall++;
                if (first_stall == 0) first_stall = i;
            end
        end
`ifdef WB_ARB_STARVE_EN
        chk("starve_first", first_stall, 9);
        chk("starve_count", n_stall, 1);
        chk("starve_drained", buf_count, 2'd0);
`else
        chk("starve_first", first_stall, 0);
        chk("starve_count", n_stall, 0);
        chk("starve_held", buf_count, 2'd1);
`endif
        idle();
        idle();

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) apply_reset(1'b1, 3);
            step($urandom_range(0, 99) < 55, rnd_addr(), {$urandom, $urandom},
                 $urandom_range(0, 99) < 45, rnd_addr(), {$urandom, $urandom});
        end
        repeat (4) idle();
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
